// File: rtl/clk_period_monitor.sv
// Measures the half-period of a slow clock in clk_in cycles. It reports lock once the
// measurements stay in tolerance, and it reports a fault when the slow clock drifts or stops.
module clk_period_monitor #(
  parameter int EXPECTED_HALF = 625001,
  parameter int TOLERANCE     = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int CNT_W         = 25
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             clear_fault,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault
);

  localparam logic [CNT_W-1:0] LO = CNT_W'(EXPECTED_HALF - TOLERANCE);
  localparam logic [CNT_W-1:0] HI = CNT_W'(EXPECTED_HALF + TOLERANCE);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED, FAULT} state_t;

  logic              sync1_q, sync2_q, edge_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  state_t            state_q, state_d;
  logic              rise_pulse_q, rise_pulse_d;
  logic              fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0]  half_period_q, half_period_d;
  logic              period_valid_q, period_valid_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;

  logic              rise_w, fall_w, strobe_w, timeout_w, good_w, publish_w;
  logic [CNT_W:0]    meas_w;

  assign rise_w    = sync2_q & ~edge_q;
  assign fall_w    = ~sync2_q & edge_q;
  assign strobe_w  = rise_w | fall_w;
  // One extra bit so that a measurement taken from a saturated counter cannot wrap.
  assign meas_w    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign good_w    = (meas_w >= {1'b0, LO}) && (meas_w <= {1'b0, HI});
  assign timeout_w = (cnt_q == HI) && !strobe_w;

  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    publish_w      = 1'b0;
    cnt_d          = strobe_w ? '0 : ((cnt_q == HI) ? HI : cnt_q + CNT_W'(1));
    rise_pulse_d   = rise_w;
    fall_pulse_d   = fall_w;
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;

    case (state_q)
      SEARCH: begin
        // The first edge only starts the interval; nothing is measured yet.
        if (strobe_w) begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end
      end
      TRACK: begin
        if (strobe_w) begin
          publish_w = 1'b1;
          if (good_w) begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
            if (good_cnt_q == LAST_GOOD) state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout_w) begin
          state_d    = SEARCH;
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (strobe_w) begin
          publish_w = 1'b1;
          if (!good_w) state_d = FAULT;
        end else if (timeout_w) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d    = SEARCH;
          cnt_d      = '0;
          good_cnt_d = '0;
        end else if (strobe_w) begin
          publish_w = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    if (publish_w) begin
      half_period_d  = meas_w[CNT_W-1:0];
      period_valid_d = 1'b1;
    end
    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      edge_q         <= 1'b0;
      cnt_q          <= '0;
      good_cnt_q     <= '0;
      state_q        <= SEARCH;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      sync1_q        <= slow_clk;
      sync2_q        <= sync1_q;
      edge_q         <= sync2_q;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      state_q        <= state_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      fault_q        <= fault_d;
    end
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor. A scoreboard queue holds the expected
// half_period values, and a monitor pops one entry at every period_valid.
module tb_clk_period_monitor;
  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             slow_clk = 1'b0;
  logic             clear_fault = 1'b0;
  logic             rise_pulse, fall_pulse, period_valid, locked, fault;
  logic [CNT_W-1:0] half_period;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int exp_rise = 0, exp_fall = 0;
  int got_rise = 0, got_fall = 0;

  clk_period_monitor #(
    .EXPECTED_HALF(10), .TOLERANCE(1), .LOCK_COUNT(4), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .clear_fault(clear_fault),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_period(half_period),
    .period_valid(period_valid), .locked(locked), .fault(fault)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Toggle slow_clk; when pub is set, the strobe from this edge must publish req.
  task automatic toggle(input bit pub, input int req);
    slow_clk = ~slow_clk;
    if (slow_clk) exp_rise++;
    else exp_fall++;
    if (pub) exp_q.push_back(req);
    $display("stim: slow_clk=%0b publish=%0b expect=%0d t=%0t", slow_clk, pub, req, $time);
  endtask

  task automatic lock_from_search(input string tag);
    toggle(1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(10);
      toggle(1'b1, 10);
    end
    wait_cyc(4);
    chk({tag, "_prelock_locked"}, int'(locked), 0);
    wait_cyc(6);
    toggle(1'b1, 10);
    wait_cyc(4);
    chk({tag, "_locked"}, int'(locked), 1);
    chk({tag, "_locked_fault"}, int'(fault), 0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (rise_pulse) got_rise++;
      if (fall_pulse) got_fall++;
      if (rise_pulse || fall_pulse) chk("rise_fall_exclusive", int'(rise_pulse && fall_pulse), 0);
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_period_valid actual=%0d required=none", half_period);
        end else begin
          int req;
          req = exp_q.pop_front();
          $display("mon: period_valid half_period=%0d expected=%0d t=%0t", half_period, req, $time);
          chk("half_period", int'(half_period), req);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cyc(3);
    chk("reset_locked", int'(locked), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_period_valid", int'(period_valid), 0);
    chk("reset_half_period", int'(half_period), 0);
    chk("reset_pulses", int'({rise_pulse, fall_pulse}), 0);
    rst = 1'b0;

    wait_cyc(5);
    lock_from_search("p1");

    // The boundary periods 11 (HI) and 9 (LO) must keep the monitor locked.
    wait_cyc(7);
    toggle(1'b1, 11);
    wait_cyc(9);
    toggle(1'b1, 9);
    wait_cyc(4);
    chk("tol_locked", int'(locked), 1);
    chk("tol_fault", int'(fault), 0);
    wait_cyc(6);
    toggle(1'b1, 10);

    // Hold slow_clk so cnt reaches HI; the timeout must fire with no edge.
    wait_cyc(14);
    chk("pre_timeout_fault", int'(fault), 0);
    chk("pre_timeout_locked", int'(locked), 1);
    wait_cyc(2);
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_locked", int'(locked), 0);
    toggle(1'b1, 12);  // saturated counter gives HI+1

    // In FAULT, strobes still publish; clear_fault returns to SEARCH.
    wait_cyc(10);
    toggle(1'b1, 10);
    wait_cyc(4);
    clear_fault = 1'b1;
    wait_cyc(1);
    clear_fault = 1'b0;
    chk("clear_fault", int'(fault), 0);
    chk("clear_locked", int'(locked), 0);
    wait_cyc(5);
    lock_from_search("p4");

    // Asynchronous reset while locked.
    wait_cyc(2);
    #2;
    rst = 1'b1;
    slow_clk = 1'b0;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_half_period", int'(half_period), 0);
    chk("arst_period_valid", int'(period_valid), 0);
    chk("arst_pulses", int'({rise_pulse, fall_pulse}), 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(5);

    // In TRACK, one half-period of 8 clears the good count.
    toggle(1'b0, 0);
    wait_cyc(10);
    toggle(1'b1, 10);
    wait_cyc(10);
    toggle(1'b1, 10);
    wait_cyc(8);
    toggle(1'b1, 8);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(10);
      toggle(1'b1, 10);
    end
    wait_cyc(4);
    chk("bad_track_not_locked", int'(locked), 0);
    wait_cyc(6);
    toggle(1'b1, 10);
    wait_cyc(4);
    chk("bad_track_relocked", int'(locked), 1);
    chk("bad_track_fault", int'(fault), 0);

    wait_cyc(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rise_count", got_rise, exp_rise);
    chk("fall_count", got_fall, exp_fall);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
